// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative HI/LO multiply/divide unit.
// The accumulate ops are only legal when MULDIV_MADD_EN is defined.
package muldiv_pkg;

    typedef enum logic [3:0] {
        MD_NONE,
        MD_MULT,
        MD_MULTU,
        MD_DIV,
        MD_DIVU,
        MD_MADD,
        MD_MADDU,
        MD_MSUB,
        MD_MSUBU
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } md_state_t;

    function automatic logic isSignedOp(input muldiv_op_t op);
        return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
    endfunction

    function automatic logic isDivOp(input muldiv_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic isAccOp(input muldiv_op_t op);
        return (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
    endfunction

    function automatic logic isSubOp(input muldiv_op_t op);
        return (op == MD_MSUB) || (op == MD_MSUBU);
    endfunction

    // Ops outside this set behave exactly like MD_NONE and are never accepted.
    function automatic logic isValidOp(input muldiv_op_t op);
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
`ifdef MULDIV_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage request/HI-LO bus between the pipeline (master) and the mult/div unit (slave).
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic                   in_valid;
    logic                   in_ready;
    muldiv_pkg::muldiv_op_t op;
    logic [WIDTH-1:0]       src_a;
    logic [WIDTH-1:0]       src_b;
    logic                   flush;
    logic                   hi_we;
    logic [WIDTH-1:0]       hi_wdata;
    logic                   lo_we;
    logic [WIDTH-1:0]       lo_wdata;
    logic [WIDTH-1:0]       hi;
    logic [WIDTH-1:0]       lo;
    logic                   busy;
    logic                   done;

    modport master (
        output in_valid, op, src_a, src_b, flush, hi_we, hi_wdata, lo_we, lo_wdata,
        input  in_ready, hi, lo, busy, done
    );

    modport slave (
        input  in_valid, op, src_a, src_b, flush, hi_we, hi_wdata, lo_we, lo_wdata,
        output in_ready, hi, lo, busy, done
    );
endinterface

// File: rtl/muldiv_signfix.sv
// Final-cycle result shaping: sign correction of product/quotient/remainder and divide-by-zero override.
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic               isDiv,
    input  logic               signA,
    input  logic               signB,
    input  logic               divZero,
    input  logic [WIDTH-1:0]   magA,
    input  logic [2*WIDTH-1:0] prod,    // quotient sits in the low half for divides
    input  logic [WIDTH-1:0]   rem,
    output logic [WIDTH-1:0]   resHi,
    output logic [WIDTH-1:0]   resLo
);

    logic               negResult;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quotFix;
    logic [WIDTH-1:0]   remFix;
    logic [WIDTH-1:0]   rawA;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        negResult = signA ^ signB;
        prodFix   = negResult ? -prod : prod;
        quotFix   = negResult ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
        remFix    = signA ? -rem : rem;
        rawA      = signA ? -magA : magA;
        resHi     = prodFix[2*WIDTH-1:WIDTH];
        resLo     = prodFix[WIDTH-1:0];
        if (isDiv) begin
            if (divZero) begin
                resHi = rawA;
                resLo = '1;
            end else begin
                resHi = remFix;
                resLo = quotFix;
            end
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative HI/LO multiply/divide unit: WIDTH shift-add or restoring-divide steps, then one sign-fix cycle.
// Define MULDIV_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      resetn,
    muldiv_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    md_state_t          state;
    muldiv_op_t         opReg;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic               signA;
    logic               signB;
    logic [2*WIDTH-1:0] prodReg;
    logic [WIDTH-1:0]   remReg;
    logic [WIDTH-1:0]   hiReg;
    logic [WIDTH-1:0]   loReg;
    logic               doneReg;

    logic               reqSigned;
    logic               reqDiv;
    logic               accept;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic               opIsDiv;

    assign reqSigned = isSignedOp(bus.op);
    assign reqDiv    = isDivOp(bus.op);
    assign accept    = bus.in_valid && (state == IDLE) && isValidOp(bus.op) && !bus.flush;
    assign absA      = (reqSigned && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
    assign absB      = (reqSigned && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;
    assign opIsDiv   = isDivOp(opReg);

    // One multiply step: conditional add into the upper half, carry kept for the right shift.
    logic [WIDTH:0] mulSum;
    assign mulSum = {1'b0, prodReg[2*WIDTH-1:WIDTH]} + (prodReg[0] ? {1'b0, magA} : '0);

    // One restoring-divide step; the shifted partial remainder needs WIDTH+1 bits.
    logic [WIDTH:0]   divShift;
    logic             divGe;
    logic [WIDTH-1:0] divDiff;
    assign divShift = {remReg, prodReg[WIDTH-1]};
    assign divGe    = divShift >= {1'b0, magB};
    assign divDiff  = divShift[WIDTH-1:0] - magB;

    logic [2*WIDTH-1:0] fixRes;
    logic [2*WIDTH-1:0] wbRes;

    muldiv_signfix #(.WIDTH(WIDTH)) uSignfix (
        .isDiv   (opIsDiv),
        .signA   (signA),
        .signB   (signB),
        .divZero (magB == '0),
        .magA    (magA),
        .prod    (prodReg),
        .rem     (remReg),
        .resHi   (fixRes[2*WIDTH-1:WIDTH]),
        .resLo   (fixRes[WIDTH-1:0])
    );

    // Accumulate ops read HI/LO at the FIX edge, so a same-cycle MTHI/MTLO at accept is included.
    always_comb begin
        wbRes = fixRes;
`ifdef MULDIV_MADD_EN
        if (isAccOp(opReg)) begin
            wbRes = isSubOp(opReg) ? ({hiReg, loReg} - fixRes) : ({hiReg, loReg} + fixRes);
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            opReg   <= MD_NONE;
            cnt     <= '0;
            magA    <= '0;
            magB    <= '0;
            signA   <= 1'b0;
            signB   <= 1'b0;
            prodReg <= '0;
            remReg  <= '0;
            hiReg   <= '0;
            loReg   <= '0;
            doneReg <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.hi_we) hiReg <= bus.hi_wdata;
                    if (bus.lo_we) loReg <= bus.lo_wdata;
                    if (accept) begin
                        state   <= RUN;
                        cnt     <= '0;
                        opReg   <= bus.op;
                        signA   <= reqSigned & bus.src_a[WIDTH-1];
                        signB   <= reqSigned & bus.src_b[WIDTH-1];
                        magA    <= absA;
                        magB    <= absB;
                        prodReg <= {{WIDTH{1'b0}}, (reqDiv ? absA : absB)};
                        remReg  <= '0;
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (opIsDiv) begin
                            remReg  <= divGe ? divDiff : divShift[WIDTH-1:0];
                            prodReg <= {prodReg[2*WIDTH-1:WIDTH], prodReg[WIDTH-2:0], divGe};
                        end else begin
                            prodReg <= {mulSum, prodReg[WIDTH-1:1]};
                        end
                        if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    if (!bus.flush) begin
                        {hiReg, loReg} <= wbRes;
                        doneReg        <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.hi       = hiReg;
    assign bus.lo       = loReg;
    assign bus.done     = doneReg;
    assign bus.busy     = (state != IDLE);
    assign bus.in_ready = (state == IDLE);

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: a 32-bit and an 8-bit instance checked against an arithmetic HI/LO model.
module tb_muldiv_iter;
    import muldiv_pkg::*;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstnA;
    logic        rstnB;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    exp_t        sbA[$];
    exp_t        sbB[$];
    exp_t        eA;
    exp_t        eB;
    logic [31:0] mHi[2];
    logic [31:0] mLo[2];
    muldiv_op_t  opList[8] = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_if #(.WIDTH(32)) busA ();
    muldiv_if #(.WIDTH(8))  busB ();

    muldiv_iter #(.WIDTH(32)) dutA (.clk(clk), .resetn(rstnA), .bus(busA));
    muldiv_iter #(.WIDTH(8))  dutB (.clk(clk), .resetn(rstnB), .bus(busB));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic noteFail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    function automatic logic [63:0] maskOf(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // Reference: plain signed/unsigned arithmetic on the architectural values.
    function automatic logic [63:0] model(input int w, input muldiv_op_t op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
        logic [63:0] m;
        longint ua, ub, sa, sb, acc, res;
        m   = maskOf(w);
        ua  = longint'({32'h0, a} & m);
        ub  = longint'({32'h0, b} & m);
        sa  = a[w-1] ? ua - (longint'(1) << w) : ua;
        sb  = b[w-1] ? ub - (longint'(1) << w) : ub;
        acc = longint'((({32'h0, hi} & m) << w) | ({32'h0, lo} & m));
        case (op)
            MD_MULT:  res = sa * sb;
            MD_MULTU: res = ua * ub;
            MD_DIV, MD_DIVU: begin
                if (ub == 0)          res = (ua << w) | longint'(m);
                else if (op == MD_DIV) res = (((sa % sb) & longint'(m)) << w) | ((sa / sb) & longint'(m));
                else                  res = (((ua % ub) & longint'(m)) << w) | ((ua / ub) & longint'(m));
            end
            MD_MADD:  res = acc + sa * sb;
            MD_MADDU: res = acc + ua * ub;
            MD_MSUB:  res = acc - sa * sb;
            MD_MSUBU: res = acc - ua * ub;
            default:  res = acc;
        endcase
        return 64'(res) & maskOf(2 * w);
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] m;
        m = 32'(maskOf(w));
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return m;
            2:       return 32'h1 << (w - 1);
            3:       return 32'h1;
            default: return $urandom() & m;
        endcase
    endfunction

    function automatic logic ready(input int u);
        return (u == 0) ? busA.in_ready : busB.in_ready;
    endfunction

    function automatic logic busyOf(input int u);
        return (u == 0) ? busA.busy : busB.busy;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input int u, input logic v, input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
        if (u == 0) begin
            busA.in_valid = v; busA.op = op; busA.src_a = a; busA.src_b = b;
        end else begin
            busB.in_valid = v; busB.op = op; busB.src_a = a[7:0]; busB.src_b = b[7:0];
        end
    endtask

    task automatic setFlush(input int u, input logic v);
        if (u == 0) busA.flush = v;
        else        busB.flush = v;
    endtask

    task automatic setMt(input int u, input logic hw, input logic [31:0] hd, input logic lw, input logic [31:0] ld);
        if (u == 0) begin
            busA.hi_we = hw; busA.hi_wdata = hd; busA.lo_we = lw; busA.lo_wdata = ld;
        end else begin
            busB.hi_we = hw; busB.hi_wdata = hd[7:0]; busB.lo_we = lw; busB.lo_wdata = ld[7:0];
        end
    endtask

    task automatic waitIdle(input int u);
        int n;
        n = 0;
        while (!ready(u) && n < 100) begin
            tick();
            n++;
        end
        if (!ready(u)) noteFail($sformatf("unit%0d_idle_wait", u));
    endtask

    // MT writes only land while the unit is idle; the model follows the same rule.
    task automatic mtWrite(input int u, input logic hw, input logic [31:0] hd, input logic lw, input logic [31:0] ld);
        logic [31:0] m;
        m = 32'(maskOf((u == 0) ? 32 : 8));
        if (ready(u)) begin
            if (hw) mHi[u] = hd & m;
            if (lw) mLo[u] = ld & m;
        end
        setMt(u, hw, hd, lw, ld);
        tick();
        setMt(u, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic issue(input int u, input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input bit expectDone, output int t);
        int          w;
        logic [63:0] r;
        logic [63:0] m;
        exp_t        e;
        w = (u == 0) ? 32 : 8;
        m = maskOf(w);
        waitIdle(u);
        t = cyc;
        setReq(u, 1'b1, op, a, b);
        if (expectDone) begin
            r     = model(w, op, a, b, mHi[u], mLo[u]);
            e.hi  = 32'((r >> w) & m);
            e.lo  = 32'(r & m);
            e.cyc = t + w + 2;
            mHi[u] = e.hi;
            mLo[u] = e.lo;
            if (u == 0) sbA.push_back(e);
            else        sbB.push_back(e);
        end
        tick();
        setReq(u, 1'b0, MD_NONE, '0, '0);
    endtask

    task automatic ignoredReq(input int u, input muldiv_op_t op, input logic withFlush, input string name);
        waitIdle(u);
        setReq(u, 1'b1, op, 32'd5, 32'd3);
        setFlush(u, withFlush);
        tick();
        setReq(u, 1'b0, MD_NONE, '0, '0);
        setFlush(u, 1'b0);
        check({name, "_ready"}, 64'(ready(u)), 64'd1);
        check({name, "_busy"}, 64'(busyOf(u)), 64'd0);
    endtask

    task automatic randomRun(input int u, input int n);
        int t;
        int w;
        int nOps;
        w = (u == 0) ? 32 : 8;
`ifdef MULDIV_MADD_EN
        nOps = 8;
`else
        nOps = 4;
`endif
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                waitIdle(u);
                mtWrite(u, 1'($urandom_range(0, 1)), pick(w), 1'($urandom_range(0, 1)), pick(w));
            end else begin
                issue(u, opList[$urandom_range(0, nOps - 1)], pick(w), pick(w), 1'b1, t);
            end
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation, value and cycle.
    always @(negedge clk) begin
        if (rstnA && busA.done) begin
            if (sbA.size() == 0) begin
                noteFail("A_unexpected_done");
            end else begin
                eA = sbA.pop_front();
                check("A_hi", 64'(busA.hi), 64'(eA.hi));
                check("A_lo", 64'(busA.lo), 64'(eA.lo));
                check("A_done_cycle", 64'(cyc), 64'(eA.cyc));
            end
        end
        if (rstnB && busB.done) begin
            if (sbB.size() == 0) begin
                noteFail("B_unexpected_done");
            end else begin
                eB = sbB.pop_front();
                check("B_hi", 64'(busB.hi), 64'(eB.hi));
                check("B_lo", 64'(busB.lo), 64'(eB.lo));
                check("B_done_cycle", 64'(cyc), 64'(eB.cyc));
            end
        end
    end

    initial begin
        int t;
        int t1;
        int t2;
        int n;
        logic [31:0] oldHi;
        logic [31:0] oldLo;

        rstnA = 1'b0;
        rstnB = 1'b0;
        setReq(0, 1'b0, MD_NONE, '0, '0);
        setReq(1, 1'b0, MD_NONE, '0, '0);
        setFlush(0, 1'b0);
        setFlush(1, 1'b0);
        setMt(0, 1'b0, '0, 1'b0, '0);
        setMt(1, 1'b0, '0, 1'b0, '0);
        mHi = '{32'h0, 32'h0};
        mLo = '{32'h0, 32'h0};
        #2;
        check("rst_hi", 64'(busA.hi), 64'd0);
        check("rst_lo", 64'(busA.lo), 64'd0);
        check("rst_done", 64'(busA.done), 64'd0);
        check("rst_busy", 64'(busA.busy), 64'd0);
        check("rst_ready", 64'(busA.in_ready), 64'd1);
        repeat (2) tick();
        rstnA = 1'b1;
        rstnB = 1'b1;
        tick();

        // Full-scale unsigned product with busy window and exact done cycle.
        issue(0, MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, t);
        for (int k = 1; k <= 33; k++) begin
            check("A_busy_run", 64'(busA.busy), 64'd1);
            check("A_ready_run", 64'(busA.in_ready), 64'd0);
            tick();
        end
        check("A_done_T34", 64'(busA.done), 64'd1);
        check("A_multu_hi", 64'(busA.hi), 64'hFFFF_FFFE);
        check("A_multu_lo", 64'(busA.lo), 64'h0000_0001);
        check("A_busy_T34", 64'(busA.busy), 64'd0);

        issue(0, MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1, t);
        issue(0, MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, t);
        issue(0, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, t);
        issue(0, MD_DIVU, 32'd7, 32'd0, 1'b1, t);
        issue(0, MD_DIV, 32'hFFFF_FFF0, 32'd0, 1'b1, t);

        // Flush mid-divide: no done, HI preserved, ready the next cycle.
        waitIdle(0);
        mtWrite(0, 1'b1, 32'h11, 1'b0, '0);
        issue(0, MD_DIVU, 32'd100, 32'd7, 1'b0, t);
        while (cyc < t + 10) tick();
        setFlush(0, 1'b1);
        tick();
        setFlush(0, 1'b0);
        check("A_flush_ready", 64'(busA.in_ready), 64'd1);
        check("A_flush_busy", 64'(busA.busy), 64'd0);
        check("A_flush_hi", 64'(busA.hi), 64'h11);
        repeat (40) tick();
        check("A_flush_hi_later", 64'(busA.hi), 64'h11);

        // MT writes during RUN are dropped.
        oldHi = mHi[0];
        oldLo = mLo[0];
        issue(0, MD_MULTU, 32'h1234, 32'h10, 1'b1, t);
        while (cyc < t + 5) tick();
        mtWrite(0, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'hCAFE_F00D);
        check("A_mt_drop_hi", 64'(busA.hi), 64'(oldHi));
        check("A_mt_drop_lo", 64'(busA.lo), 64'(oldLo));

        ignoredReq(0, MD_NONE, 1'b0, "A_none");
        ignoredReq(0, MD_MULT, 1'b1, "A_idle_flush");
`ifdef MULDIV_MADD_EN
        waitIdle(0);
        mtWrite(0, 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFF);
        issue(0, MD_MADDU, 32'd1, 32'd1, 1'b1, t);
        waitIdle(0);
        mtWrite(0, 1'b1, 32'h0, 1'b1, 32'h0);
        issue(0, MD_MSUB, 32'd2, 32'd3, 1'b1, t);
`else
        ignoredReq(0, MD_MADD, 1'b0, "A_madd_off");
`endif

        randomRun(0, 30);

        // Asynchronous reset mid-RUN takes effect with no clock edge.
        issue(0, MD_MULT, 32'h7, 32'h9, 1'b0, t);
        repeat (5) tick();
        #1;
        rstnA = 1'b0;
        #1;
        check("A_arst_hi", 64'(busA.hi), 64'd0);
        check("A_arst_lo", 64'(busA.lo), 64'd0);
        check("A_arst_busy", 64'(busA.busy), 64'd0);
        check("A_arst_ready", 64'(busA.in_ready), 64'd1);
        sbA.delete();
        mHi[0] = '0;
        mLo[0] = '0;
        tick();
        rstnA = 1'b1;
        tick();
        issue(0, MD_DIVU, 32'd1000, 32'd33, 1'b1, t);

        // 8-bit instance.
        issue(1, MD_MULTU, 32'hFF, 32'h02, 1'b1, t);
        issue(1, MD_DIVU, 32'd200, 32'd7, 1'b1, t1);
        issue(1, MD_DIVU, 32'd99, 32'd10, 1'b1, t2);
        check("B_back_to_back", 64'(t2), 64'(t1 + 10));
        issue(1, MD_DIV, 32'h80, 32'hFF, 1'b1, t);
        randomRun(1, 40);

        n = 0;
        while ((sbA.size() != 0 || sbB.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        if (sbA.size() != 0 || sbB.size() != 0) noteFail("drain");
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
Iterative, parametrised HI/LO multiply/divide unit for the MIPS execute stage.
- Successor to the single-cycle combinational mult/div path.
- Owns the architectural HI/LO registers and performs MULT/MULTU/DIV/DIVU as a multi-cycle operation.
- The pipeline stalls on `busy`. Results land directly in HI/LO.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits wide. Must be an even number, 4 or greater.
- CNT_W, $clog2(WIDTH+1), iteration counter width. Derived; must not be overridden.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request (high only in IDLE)
- op  in  muldiv_op_t  operation, sampled when the request is accepted
- src_a  in  WIDTH  operand A (multiplicand / dividend)
- src_b  in  WIDTH  operand B (multiplier / divisor)
- flush  in  1  abort the in-flight operation (exception or branch squash)
- hi_we  in  1  MTHI write enable
- hi_wdata  in  WIDTH  MTHI data
- lo_we  in  1  MTLO write enable
- lo_wdata  in  WIDTH  MTLO data
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  operation in flight (RUN or FIX)
- done  out  1  one-cycle pulse: HI/LO have just been updated by an operation

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE
  - hi=0, lo=0
  - done=0, busy=0, in_ready=1
  - counter=0
- Accept: a request is accepted when in_valid & in_ready & (op != MD_NONE) & !flush. This happens in cycle T.
- State machine:
  - IDLE -> RUN on accept. At accept, latch the magnitudes |a| and |b| (signed ops) or raw values (unsigned ops), plus the two sign bits and op.
  - RUN lasts exactly WIDTH cycles, counter 0..WIDTH-1, one bit per cycle.
    - Multiply: radix-2 shift-add into a 2*WIDTH product register.
    - Divide: restoring division, with a WIDTH+1-bit partial remainder.
  - RUN -> FIX when counter = WIDTH-1.
  - FIX lasts one cycle:
    - Apply the sign correction.
    - Write hi/lo at the FIX clock edge.
    - Go to IDLE with done=1.
- Latency: hi, lo and done show the new values in cycle T+WIDTH+2. in_ready is high again in the same cycle, so back-to-back requests are allowed.
- Multiply results:
  - {hi,lo} = full 2*WIDTH-bit product.
  - MULT negates the product when sign_a ^ sign_b.
- Divide results:
  - lo = quotient, truncated toward zero.
  - hi = remainder; its sign follows the dividend.
- Divide by zero (src_b = 0), for both DIV and DIVU:
  - lo = all ones, hi = src_a (raw value as latched).
  - No trap, same latency.
- Signed overflow (DIV with MIN / -1): lo = MIN, hi = 0.
- Flush:
  - flush=1 in RUN or FIX: next state is IDLE, hi/lo unchanged, done stays 0.
  - flush has priority over the FIX write.
  - flush in IDLE blocks acceptance in that cycle.
- MTHI/MTLO:
  - hi_we / lo_we are honoured only in IDLE; writes in RUN or FIX are dropped.
  - A write in the same cycle as an accept takes effect; the operation's later FIX write overwrites it.
- busy = (state != IDLE). in_ready = (state == IDLE).
- done is registered, is never high for two consecutive cycles from one request, and is cleared by reset.
- op = MD_NONE with in_valid high: ignored, unit stays in IDLE.

Optional Feature:
Macro MULDIV_MADD_EN.
- Defined:
  - Adds ops MADD, MADDU, MSUB and MSUBU.
  - Same RUN sequence as MULT/MULTU.
  - At FIX, {hi,lo} <= {hi,lo} ± the signed or unsigned product. Arithmetic is modulo 2^(2*WIDTH).
  - The accumulator operand is read from the HI/LO registers at the FIX edge, so a same-cycle-as-accept MTHI/MTLO value is included.
- Not defined:
  - The enum values are still declared, but they are treated exactly like MD_NONE: never accepted, no state change.

Decomposition:
- Package muldiv_pkg:
  - muldiv_op_t enum: MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU.
  - md_state_t enum: IDLE, RUN, FIX.
- One sub-module, muldiv_signfix (combinational), which:
  - Performs conditional two's-complement negation of the product, quotient and remainder.
  - Handles the divide-by-zero override.
- The FSM, counter, datapath registers and HI/LO stay in muldiv_iter.

Test Plan:
- Reset and idle:
  - resetn pulsed low mid-RUN -> hi=lo=0, busy=0, in_ready=1 immediately, with no clock edge needed.
- MULTU and MULT, WIDTH=32:
  - MULTU 0xFFFFFFFF × 0xFFFFFFFF accepted at T -> hi=0xFFFFFFFE, lo=0x00000001, done=1 exactly at T+34, busy high T+1..T+33.
  - MULT -3 × 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Signed divide:
  - DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIVU 7 / 0 -> lo=0xFFFFFFFF, hi=0x00000007.
- Flush and MT writes:
  - Start DIVU with hi=0x11, flush at T+10 -> no done, hi=0x11, in_ready=1 at T+11.
  - hi_we at T+5 during RUN -> dropped.
- WIDTH=8 instance:
  - MULTU 0xFF × 0x02 -> hi=0x01, lo=0xFE at T+10.
  - Back-to-back DIVU requests -> second accepted in the same cycle the first's done is high.
- MULDIV_MADD_EN:
  - {hi,lo}={0,0xFFFFFFFF}, MADDU 1 × 1 -> hi=1, lo=0.
  - MSUB 2 × 3 from {0,0} -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - With the macro undefined, MADD is ignored and in_ready stays 1.
